// File: rtl/hls_cdp_icvt_chn_data_in_rcv_if.sv
// Signal bundle between the chn_data_in producer, the receive skid buffer and the HLS core.
// Optional stall counter port present when HLS_CDP_ICVT_RCV_STALL_CNT_EN is defined.
interface hls_cdp_icvt_chn_data_in_rcv_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  chn_data_in_vld;
    logic                  chn_data_in_rdy;
    logic [DATA_WIDTH-1:0] chn_data_in_pd;
    logic                  core_iswt;
    logic                  core_bdwt;
    logic                  core_ivld;
    logic [DATA_WIDTH-1:0] core_pd;
    logic                  core_wen_comp;
    logic [1:0]            buf_cnt;
`ifdef HLS_CDP_ICVT_RCV_STALL_CNT_EN
    logic [15:0]           core_stall_cnt;

    modport master (
        output chn_data_in_vld, chn_data_in_pd, core_iswt, core_bdwt,
        input  chn_data_in_rdy, core_ivld, core_pd, core_wen_comp, buf_cnt, core_stall_cnt
    );
    modport slave (
        input  chn_data_in_vld, chn_data_in_pd, core_iswt, core_bdwt,
        output chn_data_in_rdy, core_ivld, core_pd, core_wen_comp, buf_cnt, core_stall_cnt
    );
`else
    modport master (
        output chn_data_in_vld, chn_data_in_pd, core_iswt, core_bdwt,
        input  chn_data_in_rdy, core_ivld, core_pd, core_wen_comp, buf_cnt
    );
    modport slave (
        input  chn_data_in_vld, chn_data_in_pd, core_iswt, core_bdwt,
        output chn_data_in_rdy, core_ivld, core_pd, core_wen_comp, buf_cnt
    );
`endif
endinterface

// File: rtl/hls_cdp_icvt_chn_data_in_rcv.sv
// 2-entry skid buffer feeding chn_data_in transfers to the HLS core stall/advance interface.
// Define HLS_CDP_ICVT_RCV_STALL_CNT_EN to add the saturating core_stall_cnt counter.
module hls_cdp_icvt_chn_data_in_rcv #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rst,
    hls_cdp_icvt_chn_data_in_rcv_if.slave chn
);

    logic [DATA_WIDTH-1:0] entry [2];
    logic                  wp;
    logic                  rp;
    logic [1:0]            cnt;
    logic [1:0]            cnt_next;
    logic                  push;
    logic                  pop;
    logic                  ivld;

    // Ready looks only at registered occupancy so there is no path from the core side.
    assign chn.chn_data_in_rdy = ~nvdla_core_rst & (cnt != 2'd2);
    assign ivld                = (cnt != 2'd0);
    assign chn.core_ivld       = ivld;
    assign chn.core_pd         = entry[rp];
    assign chn.core_wen_comp   = ~chn.core_iswt | ivld;
    assign chn.buf_cnt         = cnt;

    assign push = chn.chn_data_in_vld & chn.chn_data_in_rdy;
    assign pop  = chn.core_iswt & chn.core_bdwt & ivld;

    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + 2'd1;
        end else if (pop && !push) begin
            cnt_next = cnt - 2'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cnt      <= 2'd0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            cnt <= cnt_next;
            if (push) begin
                entry[wp] <= chn.chn_data_in_pd;
                wp        <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
        end
    end

`ifdef HLS_CDP_ICVT_RCV_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Counts cycles the core asked for data but the buffer was empty; sticks at all-ones.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_cnt <= 16'd0;
        end else if (chn.core_iswt && !ivld && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign chn.core_stall_cnt = stall_cnt;
`endif

endmodule
